// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge
//   APB3 slave front end for a synchronous FIFO. An APB write to DATA pushes
//   one word and an APB read of DATA pops one word. The bridge also keeps a
//   local occupancy count, sticky overflow/underflow flags and a threshold
//   interrupt. It can keep its own count because it is the FIFO's only
//   producer and only consumer.
//
// Ports
//   clk, rst_n          system clock (rising edge), synchronous active-low reset
//   paddr/psel/penable  APB address and control; only paddr[3:2] is decoded
//   pwrite/pwdata       APB direction and write data
//   prdata/pready       registered APB read data and ready
//   pslverr             registered APB error, valid while pready=1
//   fifo_wr_en/din      push strobe and data to the FIFO
//   fifo_rd_en          pop strobe to the FIFO
//   fifo_dout           FIFO head word (combinational, valid when not empty)
//   fifo_full/empty     FIFO status flags
//   irq                 registered level interrupt (level >= thresh)
//
// Register map (paddr[3:2])
//   0 DATA   W push / R pop
//   1 STATUS RO  {level[15:8], udf[3], ovf[2], full[1], empty[0]}
//   2 CTRL   RW  {thresh[15:8], irq_en[0]}
//   3 CLEAR  WO  bit0 clears ovf, bit1 clears udf
//
// FSM
//   state | meaning
//   IDLE  | waiting for an access cycle; side effects happen on leaving IDLE
//   RESP  | pready=1 for this single cycle, then back to IDLE

module apb_fifo_bridge #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] fifo_din,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    output logic              irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_CLEAR  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              irq_q, irq_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              irq_en_q, irq_en_d;
    logic [7:0]        thresh_q, thresh_d;

    logic              access;
    logic [1:0]        reg_sel;
    logic              wr_en, rd_en;
    logic              ovf_set, udf_set, ovf_clr, udf_clr;
    logic [31:0]       status_rd;
    logic [31:0]       ctrl_rd;

    // Address bits below the word offset and above the decode are don't-care;
    // pwdata is only partially consumed depending on the register.
    logic unused_ok;
    assign unused_ok = ^{paddr, pwdata};

    assign access  = psel & penable;
    assign reg_sel = paddr[3:2];

    always_comb begin
        status_rd       = '0;
        status_rd[0]    = fifo_empty;
        status_rd[1]    = fifo_full;
        status_rd[2]    = ovf_q;
        status_rd[3]    = udf_q;
        status_rd[15:8] = 8'(level_q);

        ctrl_rd         = '0;
        ctrl_rd[0]      = irq_en_q;
        ctrl_rd[15:8]   = thresh_q;
    end

    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        level_d   = level_q;
        irq_en_d  = irq_en_q;
        thresh_d  = thresh_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        ovf_clr   = 1'b0;
        udf_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                    case (reg_sel)
                        A_DATA: begin
                            if (pwrite) begin
                                if (!fifo_full) begin
                                    wr_en = 1'b1;
                                    if (level_q != LVL_MAX) level_d = level_q + 1'b1;
                                end else begin
                                    ovf_set   = 1'b1;
                                    pslverr_d = 1'b1;
                                end
                            end else begin
                                if (!fifo_empty) begin
                                    rd_en    = 1'b1;
                                    prdata_d = 32'(fifo_dout);
                                    if (level_q != '0) level_d = level_q - 1'b1;
                                end else begin
                                    prdata_d  = '0;
                                    udf_set   = 1'b1;
                                    pslverr_d = 1'b1;
                                end
                            end
                        end
                        A_STATUS: begin
                            if (!pwrite) prdata_d = status_rd;
                        end
                        A_CTRL: begin
                            if (pwrite) begin
                                irq_en_d = pwdata[0];
                                thresh_d = pwdata[15:8];
                            end else begin
                                prdata_d = ctrl_rd;
                            end
                        end
                        A_CLEAR: begin
                            if (pwrite) begin
                                ovf_clr = pwdata[0];
                                udf_clr = pwdata[1];
                            end else begin
                                prdata_d = '0;
                            end
                        end
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase

        // A set in the same cycle as a clear wins.
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
        udf_d = (udf_q & ~udf_clr) | udf_set;

        irq_d = irq_en_q & (32'(level_q) >= 32'(thresh_q)) & (thresh_q != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            thresh_q  <= '0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_en_q  <= irq_en_d;
            thresh_q  <= thresh_d;
        end
    end

    // Strobes are gated by reset so the FIFO never sees a push/pop in a
    // cycle where the bridge itself is being reset.
    assign fifo_wr_en = wr_en & rst_n;
    assign fifo_rd_en = rd_en & rst_n;
    assign fifo_din   = pwdata[DATA_W-1:0];

    assign prdata     = prdata_q;
    assign pready     = pready_q;
    assign pslverr    = pslverr_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Testbench for apb_fifo_bridge: a behavioural FIFO is attached to the bridge
// and every APB transfer is checked against a queue-based reference model.

module tb_apb_fifo_bridge;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready, pslverr;
    logic              fifo_wr_en, fifo_rd_en;
    logic [DATA_W-1:0] fifo_din, fifo_dout;
    logic              fifo_full, fifo_empty;
    logic              irq;

    int checks = 0;
    int errors = 0;

    apb_fifo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .fifo_din(fifo_din), .fifo_dout(fifo_dout), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached FIFO. Strobes are sampled mid-cycle and applied on the next
    // rising edge so the bridge captures the old head word at that edge.
    logic [DATA_W-1:0] fmem [DEPTH];
    int fwp = 0, frp = 0, fcnt = 0;
    logic we_s = 1'b0, re_s = 1'b0;
    logic [DATA_W-1:0] din_s = '0;
    int wr_pulses = 0, rd_pulses = 0;

    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_dout  = fmem[frp];

    always @(negedge clk) begin
        we_s  = fifo_wr_en;
        re_s  = fifo_rd_en;
        din_s = fifo_din;
        if (fifo_wr_en) wr_pulses++;
        if (fifo_rd_en) rd_pulses++;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            fwp  <= 0;
            frp  <= 0;
            fcnt <= 0;
        end else begin
            if (we_s && fcnt < DEPTH) begin
                fmem[fwp] <= din_s;
                fwp <= (fwp + 1) % DEPTH;
            end
            if (re_s && fcnt > 0) frp <= (frp + 1) % DEPTH;
            fcnt <= fcnt + ((we_s && fcnt < DEPTH) ? 1 : 0) - ((re_s && fcnt > 0) ? 1 : 0);
        end
    end

    // Reference model
    logic [DATA_W-1:0] mq[$];
    bit          m_ovf = 0, m_udf = 0, m_en = 0;
    logic [7:0]  m_thr = '0;
    logic [31:0] m_prdata = '0;

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(mq.size()), 4'h0, m_udf, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
    endfunction

    function automatic bit m_irq();
        return m_en && (mq.size() >= int'(m_thr)) && (m_thr != 8'd0);
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_ovf = 0; m_udf = 0; m_en = 0; m_thr = '0; m_prdata = '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer: setup, access (pready=0), access (pready=1).
    task automatic xfer(input bit wr, input int reg_i, input logic [31:0] wd, input bit drop = 1'b0);
        int w0 = wr_pulses;
        int r0 = rd_pulses;
        logic [31:0] exp_rd = m_prdata;
        bit exp_err = 0;
        int exp_w = 0, exp_r = 0;
        bit irq_before = m_irq();

        case (reg_i)
            0: if (wr) begin
                   if (mq.size() < DEPTH) begin mq.push_back(wd[DATA_W-1:0]); exp_w = 1; end
                   else begin m_ovf = 1; exp_err = 1; end
               end else begin
                   if (mq.size() > 0) begin exp_rd = 32'(mq.pop_front()); exp_r = 1; end
                   else begin exp_rd = '0; m_udf = 1; exp_err = 1; end
               end
            1: if (!wr) exp_rd = m_status();
            2: if (wr) begin m_en = wd[0]; m_thr = wd[15:8]; end
               else exp_rd = {16'h0, m_thr, 7'h0, m_en};
            default: if (wr) begin
                   if (wd[0]) m_ovf = 0;
                   if (wd[1]) m_udf = 0;
               end else exp_rd = '0;
        endcase
        m_prdata = exp_rd;

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = ADDR_W'(reg_i * 4); pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("pready_first_access", 32'(pready), 0);
        @(posedge clk); #1;
        check("pready_second_access", 32'(pready), 1);
        check("pslverr", 32'(pslverr), 32'(exp_err));
        check("prdata", prdata, exp_rd);
        check("irq_at_resp", 32'(irq), 32'(irq_before));
        if (drop) begin psel = 1'b0; penable = 1'b0; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("pready_one_cycle", 32'(pready), 0);
        check("pslverr_after", 32'(pslverr), 0);
        check("wr_pulses", 32'(wr_pulses - w0), 32'(exp_w));
        check("rd_pulses", 32'(rd_pulses - r0), 32'(exp_r));
        check("irq_after", 32'(irq), 32'(m_irq()));
    endtask

    initial begin
        int w0;
        logic [31:0] wd;
        int reg_i;
        bit wr;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_pready", 32'(pready), 0);
        check("reset_pslverr", 32'(pslverr), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_prdata", prdata, 0);

        // status after reset, then simple push/pop ordering
        xfer(0, 1, 0);
        xfer(1, 0, 32'h11);
        xfer(1, 0, 32'h22);
        xfer(1, 0, 32'h33);
        xfer(0, 1, 0);
        repeat (3) xfer(0, 0, 0);
        xfer(0, 1, 0);

        // fill to full, overflow, then drain
        for (int i = 0; i < DEPTH; i++) xfer(1, 0, $urandom);
        xfer(0, 1, 0);
        xfer(1, 0, 32'hAA);
        xfer(0, 1, 0);
        for (int i = 0; i < DEPTH; i++) xfer(0, 0, 0);
        xfer(1, 3, 32'h1);
        xfer(0, 1, 0);

        // underflow and its clear
        xfer(0, 0, 0);
        xfer(0, 1, 0);
        xfer(1, 3, 32'h2);
        xfer(0, 1, 0);
        xfer(0, 0, 0, 1'b1);
        xfer(0, 1, 0);
        xfer(1, 3, 32'h3);

        // threshold interrupt
        xfer(1, 2, 32'h0000_0401);
        xfer(0, 2, 0);
        for (int i = 0; i < 4; i++) xfer(1, 0, $urandom);
        xfer(0, 0, 0);
        xfer(0, 1, 0);
        xfer(0, 3, 0);

        // penable without psel is ignored
        w0 = wr_pulses + rd_pulses;
        @(posedge clk); #1;
        penable = 1'b1; pwrite = 1'b1; paddr = '0;
        repeat (2) begin
            @(negedge clk);
            check("no_psel_pready", 32'(pready), 0);
        end
        @(posedge clk); #1 penable = 1'b0;
        check("no_psel_strobes", 32'(wr_pulses + rd_pulses - w0), 0);

        // reset asserted in the first access cycle of a DATA write
        w0 = wr_pulses;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = '0; pwdata = 32'h55;
        @(posedge clk); #1;
        penable = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_wr_en", 32'(fifo_wr_en), 0);
        check("rst_mid_pready", 32'(pready), 0);
        @(posedge clk); #1;
        check("rst_after_pready", 32'(pready), 0);
        psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        check("rst_mid_no_push", 32'(wr_pulses - w0), 0);
        check("rst_mid_irq", 32'(irq), 0);
        xfer(0, 1, 0);
        xfer(1, 0, 32'h5A);
        xfer(0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            reg_i = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (reg_i == 2) wd[15:8] = 8'($urandom_range(0, 8));
            xfer(wr, reg_i, wd, ($urandom_range(0, 3) == 0));
        end
        xfer(0, 1, 0);
        xfer(0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_fifo_bridge.md
Name: apb_fifo_bridge

Overview:
- APB3 slave front end for the team's synchronous FIFO. Sits between the APB bus and the FIFO's wr_en/rd_en/din/dout/full/empty interface.
- APB writes to DATA push one word; APB reads of DATA pop one word.
- Keeps a local occupancy count, sticky error flags and a threshold interrupt. This is valid because the bridge is the FIFO's sole producer and consumer.

Parameters:
- DATA_W, 8: FIFO word width; must be ≤ 32.
- DEPTH, 16: FIFO depth; must match the attached FIFO.
- ADDR_W, 4: width of paddr; byte address, only bits [3:2] are decoded.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- paddr  in  ADDR_W  APB address.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data, registered.
- pready  out  1  APB ready, registered.
- pslverr  out  1  APB error, registered; valid when pready=1.
- fifo_wr_en  out  1  push strobe to FIFO.
- fifo_rd_en  out  1  pop strobe to FIFO.
- fifo_din  out  DATA_W  push data, equal to pwdata[DATA_W-1:0].
- fifo_dout  in  DATA_W  FIFO head word; combinational from the FIFO, valid whenever not empty.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: prdata=0, pready=0, pslverr=0, irq=0, level=0, ovf=0, udf=0, irq_en=0, thresh=0, FSM state=IDLE.
- Register map (paddr[3:2]):
  - 0 DATA: W pushes; R pops.
  - 1 STATUS (RO): bit0 fifo_empty, bit1 fifo_full, bit2 ovf, bit3 udf, bits[15:8] level. Writes are ignored, no error.
  - 2 CTRL (RW): bit0 irq_en, bits[15:8] thresh. Other bits read 0.
  - 3 CLEAR (WO): writing bit0=1 clears ovf, bit1=1 clears udf. Reads return 0.
- FSM states:
  - IDLE: on psel & penable, perform the side effect and go to RESP.
  - RESP: drive pready=1 for exactly one cycle, then go to IDLE.
- Transfer timing: every transfer is setup + 1 wait + 1 ready cycle. pready is 0 in the first access cycle and 1 in the second.
- Strobes: fifo_wr_en and fifo_rd_en are combinational, high only in IDLE while psel & penable. Each is therefore at most a 1-cycle pulse per transfer.
- DATA write:
  - If !fifo_full: fifo_wr_en=1; level += 1 at the edge.
  - If fifo_full: no strobe; ovf set; pslverr=1 in RESP.
- DATA read:
  - If !fifo_empty: fifo_rd_en=1; prdata captures zero-extended fifo_dout at the same edge; level -= 1.
  - If fifo_empty: no strobe; prdata=0; udf set; pslverr=1.
- prdata: registered at the IDLE→RESP edge for all reads. It holds its value until the next read. For writes prdata is unchanged.
- level: width $clog2(DEPTH)+1 bits, saturating at 0 and DEPTH. Push and pop can never coincide, since only one transfer is in flight.
- ovf/udf: if a set and a CLEAR-write occur in the same cycle, set wins. This cannot happen within a single transfer; the rule is stated for robustness.
- irq: registered each cycle as irq_en & (level ≥ thresh) & (thresh ≠ 0). It updates one cycle after level changes.
- Protocol edge cases:
  - psel dropped while in RESP: the FSM still returns to IDLE with no side effect.
  - penable without psel: ignored.
- Reset mid-transfer: FSM returns to IDLE, pready=0, no strobe in the reset cycle. The attached FIFO must be reset together.

Test Plan:
- After reset: read STATUS → prdata=0x0000_0001 (empty), pready high for exactly one cycle, pslverr=0, irq=0.
- 3 DATA writes 0x11, 0x22, 0x33 → one fifo_wr_en pulse each. STATUS reads 0x0000_0300. Then 3 DATA reads return 0x11, 0x22, 0x33 in order, and STATUS returns to 0x0000_0001.
- 16 writes with DEPTH=16 → STATUS=0x0000_1002. 17th write 0xAA → pslverr=1, no fifo_wr_en, STATUS=0x0000_1006. Subsequent read returns the first word, not 0xAA.
- Read DATA when empty → prdata=0, pslverr=1, no fifo_rd_en, STATUS bit3=1. Write CLEAR=0x2 → bit3=0; a new read error sets it again.
- Write CTRL=0x0000_0401 (thresh 4, en) → irq=0 after 3 pushes. 4th push → irq=1 one cycle after the RESP edge. One pop → irq=0.
- Assert rst_n=0 in the first access cycle of a DATA write → no fifo_wr_en, pready=0, level=0 after reset. Next transfer behaves normally.
